// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan
//  Purpose  : Four-digit time-multiplexed 7-segment driver for a common-anode
//             display: digit scan with dead-time blanking, leading-zero
//             suppression and a once-per-frame input latch.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan #(
    parameter int DIV         = 50000,
    parameter int BLANK       = 16,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] val,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int            C_PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_PW-1:0] C_P_LAST = C_PW'(DIV - 1);

    // A slot must hold at least one lit cycle after the blank, and the
    // prescaler needs at least two states.
    if (DIV < 2 || DIV < BLANK + 1) begin : g_bad_cfg
        $error("seg_scan: DIV must be >= 2 and >= BLANK+1");
    end

    logic [C_PW-1:0] r_p;
    logic [1:0]      r_d;
    logic [15:0]     r_sval;
    logic [3:0]      r_sdp;

    logic            w_frame_start;
    logic            w_last;
    logic            w_past_blank;
    logic [15:0]     w_cur_val;
    logic [3:0]      w_cur_dp;
    logic [3:0]      w_nib;
    logic            w_suppr;
    logic            w_vis;
    logic [6:0]      w_dec;

    assign w_frame_start = (r_p == '0) && (r_d == 2'd0);
    assign w_last        = (r_p == C_P_LAST);

    // With BLANK=0 the slot is lit from p=0, so the value being latched on
    // this very edge must already be the one displayed.
    assign w_cur_val = w_frame_start ? val   : r_sval;
    assign w_cur_dp  = w_frame_start ? dp_in : r_sdp;
    assign w_nib     = w_cur_val[{r_d, 2'b00} +: 4];

    if (BLANK == 0) begin : g_no_blank
        assign w_past_blank = 1'b1;
    end else begin : g_blank
        localparam logic [C_PW-1:0] C_BLANK = C_PW'(BLANK);
        assign w_past_blank = (r_p >= C_BLANK);
    end

    // Leading-zero suppression: digit d is dark when it and every digit to
    // its left are zero; the rightmost digit always shows.
    always_comb begin
        w_suppr = 1'b0;
        if (LZ_SUPPRESS != 0) begin
            case (r_d)
                2'd1:    w_suppr = (w_cur_val[15:4]  == 12'h000);
                2'd2:    w_suppr = (w_cur_val[15:8]  == 8'h00);
                2'd3:    w_suppr = (w_cur_val[15:12] == 4'h0);
                default: w_suppr = 1'b0;
            endcase
        end
    end

    assign w_vis = en && w_past_blank && !w_suppr;

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        w_dec = 7'b1111111;
        case (w_nib)
            4'h0: w_dec = 7'b1000000;
            4'h1: w_dec = 7'b1111001;
            4'h2: w_dec = 7'b0100100;
            4'h3: w_dec = 7'b0110000;
            4'h4: w_dec = 7'b0011001;
            4'h5: w_dec = 7'b0010010;
            4'h6: w_dec = 7'b0000010;
            4'h7: w_dec = 7'b1111000;
            4'h8: w_dec = 7'b0000000;
            4'h9: w_dec = 7'b0010000;
            4'hA: w_dec = 7'b0001000;
            4'hB: w_dec = 7'b0000011;
            4'hC: w_dec = 7'b1000110;
            4'hD: w_dec = 7'b0100001;
            4'hE: w_dec = 7'b0000110;
            4'hF: w_dec = 7'b0001110;
            default: w_dec = 7'b1111111;
        endcase
    end

    // Prescaler and digit index; held at the frame origin while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_p <= '0;
            r_d <= 2'd0;
        end else if (w_last) begin
            r_p <= '0;
            r_d <= r_d + 2'd1;
        end else begin
            r_p <= r_p + C_PW'(1);
        end
    end

    // Shadow copy of the display data, refreshed only at the frame origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sval <= 16'h0000;
            r_sdp  <= 4'h0;
        end else if (w_frame_start) begin
            r_sval <= val;
            r_sdp  <= dp_in;
        end
    end

    // Registered drive outputs; anything not visible is fully dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= en && w_last && (r_d == 2'd3);
            if (w_vis) begin
                an  <= ~(4'b0001 << r_d);
                seg <= w_dec;
                dp  <= ~w_cur_dp[r_d];
            end else begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Four-digit, time-multiplexed 7-segment display driver. It consumes the 4-bit count nibbles from the free-running counter stage, packed into a 16-bit value, and produces the anode and segment drives for a common-anode display. It scans the digits, inserts a dead-time blank between digits, suppresses leading zeros, and latches its input once per frame so the display never tears.

## Interface
- DIV, 50000: clock cycles per digit slot; must be ≥ BLANK+1 and ≥ 2.
- BLANK, 16: blank (dead-time) cycles at the start of each slot; may be 0.
- LZ_SUPPRESS, 1: 1 = blank leading zero digits; 0 = show all digits.

- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  display enable.
- val  in  16  four hex nibbles; val[3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal-point request per digit; active-high.
- an  out  4  digit anodes, active-low; an[i] drives digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame.

## Operation
- State registers:
  - prescaler p, width clog2(DIV), counts 0..DIV-1 and wraps.
  - digit index d, 2 bits; increments when p==DIV-1 and wraps 3→0.
  - shadow registers sval[15:0] and sdp[3:0].
- Frame latch: on the edge where p==0 and d==0, sval<=val and sdp<=dp_in. Input changes mid-frame have no effect until the next frame.
- Digit visibility for digit d:
  - Visible = (p ≥ BLANK) and not suppressed.
  - Suppressed when LZ_SUPPRESS=1, d≠0, and sval nibbles d..3 are all zero.
  - Digit 0 is never suppressed.
- Outputs when digit d is visible:
  - an = ~(4'b0001<<d).
  - seg = hex decode of nibble d.
  - dp = ~sdp[d].
- Outputs when digit d is not visible: an=1111, seg=1111111, dp=1.
- A suppressed digit also blanks its dp, even if sdp[d]=1.
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- en=0:
  - p, d and frame_tick are held at 0 (synchronous clear each cycle).
  - Outputs are forced off.
  - The first cycle after en rises is p=0, d=0, so a fresh frame starts with a latch.
- rst=1 (overrides en): p=0, d=0, sval=0, sdp=0; all outputs at reset values.
- Reset values: an=1111, seg=1111111, dp=1, frame_tick=0.

## Timing
- All outputs are registered.
- Outputs in cycle t reflect the (p, d, sval, sdp) state of cycle t-1, i.e. one cycle of latency.
- Latched value path:
  - The val sampled at the p=0/d=0 edge first appears on seg at the cycle where p=BLANK+1 of digit 0.
  - With BLANK=0, it appears at p=1.
- Slot length is exactly DIV cycles; frame length is 4·DIV cycles.
- Each digit is lit for DIV-BLANK consecutive cycles per frame.
- There is never an overlap of two active anodes, including across slot boundaries.
- frame_tick is high for exactly one cycle, in the cycle after the state p==DIV-1, d==3.
- Synchronous reset mid-frame: outputs are off from the cycle after rst is sampled; scanning restarts at d=0 after release.
- Simultaneous rst and en=1: reset wins.

## Test plan
Common setup: DIV=8, BLANK=2 unless stated otherwise.

- **Reset:** hold rst 3 cycles with en=1, val=FFFF → an=1111, seg=1111111, dp=1, frame_tick=0 throughout and one cycle after release.
- **Scan:** en=1, val=16'h12AF, dp_in=0100, LZ_SUPPRESS=1 → each slot shows 2 blank cycles then 6 lit cycles:
  - digit 0: an=1110, seg=0001110.
  - digit 1: an=1101, seg=0001000.
  - digit 2: an=1011, seg=0100100, dp=0.
  - digit 3: an=0111, seg=1111001.
- **Leading zeros:**
  - val=0005 → slots 1–3 keep an=1111; digit 0 seg=0010010.
  - val=0000 → digit 0 seg=1000000.
  - val=0000 with LZ_SUPPRESS=0 → all four digits show 1000000.
- **No tearing:** change val from 1234 to ABCD at p=3, d=1 → the rest of that frame shows 1234; the next frame shows ABCD.
- **frame_tick:** free run 100 cycles → pulses are exactly 32 cycles apart, each 1 cycle wide, and coincide with the transition from digit 3 to digit 0.
- **Reset/enable mid-frame:**
  - Assert rst during digit 2 → outputs off next cycle; after release, digit 0 is lit at cycle BLANK+2.
  - Drop en for 5 cycles → same restart behaviour; with DIV=1 the configuration is rejected (elaboration error).
